// File: rtl/program_memory.sv
// 256x8 program RAM with a byte-stream loader; cpu_run gates CPU access once loading completes.
// Optional build macro: WRITE_PROTECT_EN blocks CPU writes into the loaded image.
module program_memory #(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] IDLE_RD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              ram_we,
    output logic [DATA_W-1:0] ram_out,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] load_count,
    output logic              cpu_run,
    output logic              prot_fault
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              start_ok;
    logic              accept;
    logic              done;
    logic              wp_hit;
    logic              cpu_wr;

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        start_ok   = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    start_ok   = 1'b1;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                accept     = load_valid;
                // count wraps in ADDR_W bits, so len==0 completes on the DEPTH-th byte
                if (load_valid && ((load_count + ADDR_W'(1)) == len)) begin
                    done       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                    start_ok   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef WRITE_PROTECT_EN
    assign wp_hit = (len == '0) || (ram_addr < len);
`else
    assign wp_hit = 1'b0;
`endif

    assign cpu_wr = (state == RUN) && ram_we && !wp_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            len        <= '0;
            load_count <= '0;
            cpu_run    <= 1'b0;
        end else begin
            state   <= state_next;
            cpu_run <= (state_next == RUN);
            if (start_ok) begin
                ptr        <= '0;
                len        <= load_len;
                load_count <= '0;
            end else if (accept) begin
                ptr        <= done ? '0 : ptr + ADDR_W'(1);
                load_count <= load_count + ADDR_W'(1);
            end
        end
    end

    // Contents deliberately have no reset so a loaded image survives rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr] <= load_data;
        end else if (cpu_wr) begin
            mem[ram_addr] <= ram_data;
        end
    end

    always_comb begin
        ram_out = IDLE_RD;
        if (state == RUN) begin
            ram_out = mem[ram_addr];
        end
    end

`ifdef WRITE_PROTECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prot_fault <= 1'b0;
        end else if (start_ok) begin
            prot_fault <= 1'b0;
        end else if ((state == RUN) && ram_we && wp_hit) begin
            prot_fault <= 1'b1;
        end
    end
`else
    assign prot_fault = 1'b0;
`endif

endmodule
